keypad_lock_ctrl: RTL and testbench

Upstream stage of the door monitor. Decodes a 4-digit keypad PIN and drives the `locked` level that the door alarm logic consumes. Handles wrong-PIN counting with a timed lockout, entry inactivity timeout, and auto-relock after the door has been closed for a set time.

---
 rtl/keypad_lock_ctrl_pkg.sv | 29 ++
 rtl/keypad_lock_ctrl_if.sv | 25 ++
 rtl/keypad_lock_ctrl_timer.sv | 36 +++
 rtl/keypad_lock_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_lock_ctrl_pkg.sv
// Shared home-automation definitions: lock FSM states, keypad codes and
// elaboration-time width helpers used by the keypad lock and its timer.
package smart_home_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_t;

  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  // Bits needed to hold values 0..value-1 (never less than one bit)
  function automatic int sh_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int sh_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_if.sv
// Keypad/door-sensor inputs and lock status outputs of the keypad lock.
// The master side (keypad front end, door sensor) drives the requests; the
// slave side (lock controller) drives the lock status back.
interface keypad_lock_ctrl_if;

  logic       key_valid;
  logic [3:0] key_code;
  logic       lock_cmd;
  logic       door_closed;
  logic       locked;
  logic       lockout;
  logic       unlock_pulse;
  logic       fail_pulse;

  modport master (
    output key_valid, key_code, lock_cmd, door_closed,
    input  locked, lockout, unlock_pulse, fail_pulse
  );

  modport slave (
    input  key_valid, key_code, lock_cmd, door_closed,
    output locked, lockout, unlock_pulse, fail_pulse
  );

endinterface

// File: rtl/keypad_lock_ctrl_timer.sv
// sh_timer: saturating up-counter with synchronous clear and enable.
// 'expired' is high once the count has reached 'limit', and also on the
// cycle whose enabled edge will bring the count up to 'limit', so the owner
// can act on the very edge where the limit is reached.
module sh_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;

  // Count up while enabled, hold at all-ones, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Limit reached already, or reached by this enabled edge
  always_comb begin
    expired = (cnt_q >= limit) || (en && ((cnt_q + 1'b1) == limit));
  end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad PIN lock. Collects PIN digits, unlocks on a match, counts wrong
// entries toward a timed lockout, abandons idle entries and relocks once the
// door has stayed shut long enough. One shared timer serves the entry idle
// timeout, the relock delay and the lockout duration.
module keypad_lock_ctrl
  import smart_home_pkg::*;
#(
  parameter int          PIN_DIGITS     = 4,
  parameter logic [15:0] PIN            = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          RELOCK_CYCLES  = 500,
  parameter int          ENTRY_TIMEOUT  = 200
) (
  input logic               clk,
  input logic               rst_n,
  keypad_lock_ctrl_if.slave bus
);

  localparam int CODE_W = 4 * PIN_DIGITS;
  localparam int CNT_W  = sh_clog2(PIN_DIGITS + 1);
  localparam int TRY_W  = sh_clog2(MAX_TRIES + 1);
  localparam int TMR_W  = sh_clog2(sh_max3(LOCKOUT_CYCLES, RELOCK_CYCLES, ENTRY_TIMEOUT) + 1);

  localparam logic [CODE_W-1:0] PIN_CODE    = PIN[CODE_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(PIN_DIGITS);
  localparam logic [TRY_W-1:0]  TRY_LIMIT   = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  ENTRY_LIM   = TMR_W'(ENTRY_TIMEOUT);
  localparam logic [TMR_W-1:0]  RELOCK_LIM  = TMR_W'(RELOCK_CYCLES);
  localparam logic [TMR_W-1:0]  LOCKOUT_LIM = TMR_W'(LOCKOUT_CYCLES);

  lock_state_t       state_q, state_d;
  logic [TRY_W-1:0]  tries_q, tries_d, tries_inc;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d, dcnt_new;
  logic [CODE_W-1:0] shift_q, shift_d, shift_new;
  logic              locked_q, lockout_q, unlock_q, fail_q;
  logic              unlock_d, fail_d;
  logic              key_digit, key_clear;
  logic              entry_full, code_match;
  logic              restart;
  logic              tmr_clr, tmr_en, tmr_exp;
  logic [TMR_W-1:0]  tmr_lim;

  // Decode the key strobe and build the candidate code including this digit
  always_comb begin
    key_digit  = bus.key_valid && (bus.key_code <= KEY_MAX_DIGIT);
    key_clear  = bus.key_valid && (bus.key_code == KEY_CLEAR);
    if (state_q == LOCKED) begin
      dcnt_new  = CNT_W'(1);
      shift_new = CODE_W'(bus.key_code);
    end else begin
      dcnt_new  = dcnt_q + 1'b1;
      shift_new = (shift_q << 4) | CODE_W'(bus.key_code);
    end
    entry_full = (dcnt_new == CNT_FULL);
    code_match = (shift_new == PIN_CODE);
    tries_inc  = tries_q + 1'b1;
  end

  // Select what the shared timer measures in the current state
  always_comb begin
    tmr_en  = 1'b0;
    tmr_lim = '1;
    unique case (state_q)
      ENTRY: begin
        tmr_en  = 1'b1;
        tmr_lim = ENTRY_LIM;
      end
      UNLOCKED: begin
        tmr_en  = bus.door_closed;
        tmr_lim = RELOCK_LIM;
      end
      LOCKOUT: begin
        tmr_en  = 1'b1;
        tmr_lim = LOCKOUT_LIM;
      end
      default: begin
        tmr_en  = 1'b0;
        tmr_lim = '1;
      end
    endcase
  end

  // Next-state, try counting and pulse decisions
  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    dcnt_d   = dcnt_q;
    shift_d  = shift_q;
    unlock_d = 1'b0;
    fail_d   = 1'b0;
    restart  = 1'b0;
    unique case (state_q)
      LOCKED, ENTRY: begin
        if (key_digit) begin
          // A key in the same cycle as the idle timeout takes precedence
          restart = 1'b1;
          shift_d = shift_new;
          dcnt_d  = dcnt_new;
          state_d = ENTRY;
          if (entry_full) begin
            dcnt_d = '0;
            if (code_match) begin
              state_d  = UNLOCKED;
              tries_d  = '0;
              unlock_d = 1'b1;
            end else begin
              tries_d = tries_inc;
              fail_d  = 1'b1;
              state_d = (tries_inc == TRY_LIMIT) ? LOCKOUT : LOCKED;
            end
          end
        end else if ((state_q == ENTRY) && (key_clear || tmr_exp)) begin
          state_d = LOCKED;
          dcnt_d  = '0;
        end
      end
      UNLOCKED: begin
        // A door that is open cannot be locked by command
        if (tmr_exp || (bus.lock_cmd && bus.door_closed)) begin
          state_d = LOCKED;
        end
      end
      LOCKOUT: begin
        if (tmr_exp) begin
          state_d = LOCKED;
          tries_d = '0;
        end
      end
      default: begin
        state_d = LOCKED;
      end
    endcase
  end

  // Timer restarts on every state change, every accepted digit and any
  // open-door cycle while unlocked
  assign tmr_clr = restart || (state_d != state_q) ||
                   ((state_q == UNLOCKED) && !bus.door_closed);

  sh_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_lim),
    .expired (tmr_exp)
  );

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOCKED;
      tries_q   <= '0;
      dcnt_q    <= '0;
      locked_q  <= 1'b1;
      lockout_q <= 1'b0;
      unlock_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      dcnt_q    <= dcnt_d;
      locked_q  <= (state_d != UNLOCKED);
      lockout_q <= (state_d == LOCKOUT);
      unlock_q  <= unlock_d;
      fail_q    <= fail_d;
    end
  end

  // Digit shift register; only read after a first digit has loaded it
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.locked       = locked_q;
  assign bus.lockout      = lockout_q;
  assign bus.unlock_pulse = unlock_q;
  assign bus.fail_pulse   = fail_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: vector tables of {inputs, expected outputs}
// applied one per clock through a scoreboard queue, plus hand-written
// asynchronous-reset sequences. Outputs are packed {locked, lockout,
// unlock_pulse, fail_pulse}.
module tb_keypad_lock_ctrl;

  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] E_L   = 4'b1000;  // locked, quiet
  localparam logic [3:0] E_UN  = 4'b0000;  // unlocked, quiet
  localparam logic [3:0] E_UP  = 4'b0010;  // unlock pulse
  localparam logic [3:0] E_F   = 4'b1001;  // fail pulse
  localparam logic [3:0] E_FLO = 4'b1101;  // fail pulse entering lockout
  localparam logic [3:0] E_LO  = 4'b1100;  // in lockout

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keypad_lock_ctrl_if bus ();

  keypad_lock_ctrl #(
    .PIN_DIGITS     (4),
    .PIN            (16'h1234),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (20),
    .RELOCK_CYCLES  (10),
    .ENTRY_TIMEOUT  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       lc;
    logic       dc;
    logic [3:0] ex;
    string      tag;
  } vec_t;

  typedef struct {
    logic [3:0] ex;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [3:0] obs;
  assign obs = {bus.locked, bus.lockout, bus.unlock_pulse, bus.fail_pulse};

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: {locked,lockout,unlock,fail} got %b want %b at %0t", tag, act, ex, $time);
    end
  endtask

  task automatic drive(input logic kv, input logic [3:0] kc, input logic lc, input logic dc);
    bus.key_valid   = kv;
    bus.key_code    = kc;
    bus.lock_cmd    = lc;
    bus.door_closed = dc;
  endtask

  task automatic add(input logic kv, input logic [3:0] kc, input logic lc, input logic dc,
                     input logic [3:0] ex, input string tag);
    vec_t v;
    v.kv = kv; v.kc = kc; v.lc = lc; v.dc = dc; v.ex = ex; v.tag = tag;
    tbl.push_back(v);
  endtask

  task automatic key(input logic [3:0] k, input logic dc, input logic [3:0] ex, input string tag);
    add(1'b1, k, 1'b0, dc, ex, tag);
  endtask

  task automatic idle(input int n, input logic dc, input logic [3:0] ex, input string tag);
    for (int i = 0; i < n; i++) add(1'b0, 4'h0, 1'b0, dc, ex, tag);
  endtask

  task automatic lockc(input logic dc, input logic [3:0] ex, input string tag);
    add(1'b0, 4'h0, 1'b1, dc, ex, tag);
  endtask

  task automatic entry(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] d3, input logic dc, input logic [3:0] pre,
                       input logic [3:0] last, input string tag);
    key(d0, dc, pre, tag);
    key(d1, dc, pre, tag);
    key(d2, dc, pre, tag);
    key(d3, dc, last, tag);
  endtask

  // One vector per clock: drive on the falling edge, expect result after the rising edge
  task automatic run_table();
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].kv, tbl[i].kc, tbl[i].lc, tbl[i].dc);
      e.ex  = tbl[i].ex;
      e.tag = tbl[i].tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", obs, 4'bxxxx);
      end else begin
        e = sb_q.pop_front();
        check(e.tag, obs, e.ex);
      end
    end
    tbl.delete();
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.lock_cmd  = 1'b0;
  endtask

  // Pulse reset low between clock edges (called right after a falling edge)
  task automatic mid_cycle_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check(tag, obs, E_L);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("reset_state", obs, E_L);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_reset_idle", obs, E_L);

    // Correct PIN with door open, lock_cmd behaviour
    entry(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, E_L, E_UP, "unlock_open_door");
    idle(1, 1'b0, E_UN, "unlocked_idle");
    lockc(1'b0, E_UN, "lock_cmd_door_open");
    lockc(1'b1, E_L, "lock_cmd_door_closed");

    // Three wrong PINs, lockout, keys ignored, expiry
    entry(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, E_L, E_F,   "wrong_1");
    entry(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, E_L, E_F,   "wrong_2");
    entry(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, E_L, E_FLO, "wrong_3_lockout");
    entry(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, E_LO, E_LO, "keys_in_lockout");
    idle(15, 1'b0, E_LO, "lockout_hold");
    idle(1, 1'b0, E_L, "lockout_expire");
    entry(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, E_L, E_UP, "unlock_after_lockout");

    // Auto-relock with an open-door blip restarting the delay
    idle(6, 1'b1, E_UN, "door_closed_6");
    idle(1, 1'b0, E_UN, "door_open_blip");
    idle(9, 1'b1, E_UN, "relock_wait");
    idle(1, 1'b1, E_L, "relock_10");

    // Seven idle cycles is still within the entry window
    key(4'd1, 1'b1, E_L, "idle7_d1");
    key(4'd2, 1'b1, E_L, "idle7_d2");
    idle(7, 1'b1, E_L, "idle7_wait");
    key(4'd3, 1'b1, E_L, "idle7_d3");
    key(4'd4, 1'b1, E_UP, "idle7_unlock");
    lockc(1'b1, E_L, "lock_cmd_2");

    // Ten idle cycles times out; 3,4 starts a fresh entry
    key(4'd1, 1'b1, E_L, "timeout_d1");
    key(4'd2, 1'b1, E_L, "timeout_d2");
    idle(10, 1'b1, E_L, "timeout_idle");
    key(4'd3, 1'b1, E_L, "timeout_d3");
    key(4'd4, 1'b1, E_L, "timeout_no_unlock");
    key(KEY_C, 1'b1, E_L, "timeout_clear");

    // Clear key discards a partial entry without counting a try
    key(4'd1, 1'b1, E_L, "clear_d1");
    key(4'd2, 1'b1, E_L, "clear_d2");
    key(4'd4, 1'b1, E_L, "clear_d3");
    key(KEY_C, 1'b1, E_L, "clear_no_fail");
    entry(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, E_L, E_UP, "unlock_after_clear");
    lockc(1'b1, E_L, "lock_cmd_3");

    // A correct PIN clears the try count
    entry(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, E_L, E_F,  "wrong_a");
    entry(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, E_L, E_UP, "unlock_clears_tries");
    lockc(1'b1, E_L, "lock_cmd_4");
    entry(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, E_L, E_F,  "wrong_b");
    entry(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, E_L, E_F,  "wrong_c_no_lockout");
    key(4'd1, 1'b1, E_L, "pre_reset_d1");
    key(4'd2, 1'b1, E_L, "pre_reset_d2");
    run_table();

    // Asynchronous reset mid-entry with two tries already counted
    mid_cycle_reset("async_reset_mid_entry");
    key(4'd3, 1'b0, E_L, "post_reset_d3");
    key(4'd4, 1'b0, E_L, "post_reset_no_unlock");
    key(KEY_C, 1'b0, E_L, "post_reset_clear");
    entry(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, E_L, E_F,  "post_reset_tries_cleared");
    entry(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, E_L, E_UP, "post_reset_unlock");
    idle(2, 1'b0, E_UN, "post_reset_unlocked");
    run_table();

    // Asynchronous reset while unlocked forces locked before the next edge
    mid_cycle_reset("async_reset_unlocked");
    @(posedge clk);
    #1 check("async_reset_unlocked_hold", obs, E_L);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
